// File: rtl/label_bbox_scan.sv
// label_bbox_scan: scans a label map after labeling finishes and streams per-label count/bounding-box records.
// Optional macro BBOX_CENTROID_EN builds row/column coordinate sum accumulators; otherwise out_rsum/out_csum are 0.
module label_bbox_scan #(
   parameter  int IMG_W     = 32,
   parameter  int IMG_H     = 32,
   parameter  int MAX_LABEL = 32,
   parameter  int LABEL_W   = 8,
   localparam int ADDR_W    = $clog2(IMG_W * IMG_H),
   localparam int COL_W     = $clog2(IMG_W),
   localparam int ROW_W     = $clog2(IMG_H),
   localparam int CNT_W     = ADDR_W + 1,
   localparam int SUM_W     = ADDR_W + ((ROW_W > COL_W) ? ROW_W : COL_W),
   localparam int IDX_W     = $clog2(MAX_LABEL)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [ADDR_W-1:0]  sram_a,
   input  logic [LABEL_W-1:0] sram_q,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LABEL_W-1:0] out_label,
   output logic [CNT_W-1:0]   out_count,
   output logic [ROW_W-1:0]   out_rmin,
   output logic [ROW_W-1:0]   out_rmax,
   output logic [COL_W-1:0]   out_cmin,
   output logic [COL_W-1:0]   out_cmax,
   output logic [SUM_W-1:0]   out_rsum,
   output logic [SUM_W-1:0]   out_csum
);

   typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SCAN, ST_DRAIN, ST_EMIT} state_t;

   state_t            state_r;
   logic [IDX_W-1:0]  clr_idx_r;
   logic [IDX_W-1:0]  emit_idx_r;
   logic              proc_valid_r;
   logic [ADDR_W-1:0] proc_addr_r;

   logic [CNT_W-1:0]  cnt_r  [MAX_LABEL];
   logic [ROW_W-1:0]  rmin_r [MAX_LABEL];
   logic [ROW_W-1:0]  rmax_r [MAX_LABEL];
   logic [COL_W-1:0]  cmin_r [MAX_LABEL];
   logic [COL_W-1:0]  cmax_r [MAX_LABEL];
`ifdef BBOX_CENTROID_EN
   logic [SUM_W-1:0]  rsum_r [MAX_LABEL];
   logic [SUM_W-1:0]  csum_r [MAX_LABEL];
`endif

   logic [ROW_W-1:0]  pix_row_s;
   logic [COL_W-1:0]  pix_col_s;
   logic [IDX_W-1:0]  upd_idx_s;
   logic              upd_en_s;
   logic              ovf_hit_s;
   logic              last_idx_s;

   // Decode the pixel whose label is returning from the sram this cycle
   always_comb begin
      pix_row_s  = proc_addr_r[ADDR_W-1:COL_W];
      pix_col_s  = proc_addr_r[COL_W-1:0];
      upd_idx_s  = sram_q[IDX_W-1:0];
      upd_en_s   = proc_valid_r && (sram_q != {LABEL_W{1'b0}}) && (sram_q < LABEL_W'(MAX_LABEL));
      ovf_hit_s  = proc_valid_r && (sram_q >= LABEL_W'(MAX_LABEL));
      last_idx_s = (emit_idx_r == IDX_W'(MAX_LABEL - 1));
   end

   // Statistics table: cleared entry-by-entry before the scan, then updated once per returned pixel
   always_ff @(posedge clk) begin
      if (state_r == ST_CLEAR) begin
         cnt_r[clr_idx_r]  <= {CNT_W{1'b0}};
         rmin_r[clr_idx_r] <= ROW_W'(IMG_H - 1);
         rmax_r[clr_idx_r] <= {ROW_W{1'b0}};
         cmin_r[clr_idx_r] <= COL_W'(IMG_W - 1);
         cmax_r[clr_idx_r] <= {COL_W{1'b0}};
`ifdef BBOX_CENTROID_EN
         rsum_r[clr_idx_r] <= {SUM_W{1'b0}};
         csum_r[clr_idx_r] <= {SUM_W{1'b0}};
`endif
      end else if (upd_en_s) begin
         if (cnt_r[upd_idx_s] != CNT_W'(IMG_W * IMG_H)) begin
            cnt_r[upd_idx_s] <= cnt_r[upd_idx_s] + CNT_W'(1);
         end
         if (pix_row_s < rmin_r[upd_idx_s]) rmin_r[upd_idx_s] <= pix_row_s;
         if (pix_row_s > rmax_r[upd_idx_s]) rmax_r[upd_idx_s] <= pix_row_s;
         if (pix_col_s < cmin_r[upd_idx_s]) cmin_r[upd_idx_s] <= pix_col_s;
         if (pix_col_s > cmax_r[upd_idx_s]) cmax_r[upd_idx_s] <= pix_col_s;
`ifdef BBOX_CENTROID_EN
         rsum_r[upd_idx_s] <= rsum_r[upd_idx_s] + SUM_W'(pix_row_s);
         csum_r[upd_idx_s] <= csum_r[upd_idx_s] + SUM_W'(pix_col_s);
`endif
      end
   end

`ifndef BBOX_CENTROID_EN
   assign out_rsum = {SUM_W{1'b0}};
   assign out_csum = {SUM_W{1'b0}};
`endif

   // Control FSM with registered address, status and record outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         clr_idx_r    <= {IDX_W{1'b0}};
         emit_idx_r   <= {IDX_W{1'b0}};
         proc_valid_r <= 1'b0;
         proc_addr_r  <= {ADDR_W{1'b0}};
         sram_a       <= {ADDR_W{1'b0}};
         busy         <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
         out_valid    <= 1'b0;
         out_label    <= {LABEL_W{1'b0}};
         out_count    <= {CNT_W{1'b0}};
         out_rmin     <= {ROW_W{1'b0}};
         out_rmax     <= {ROW_W{1'b0}};
         out_cmin     <= {COL_W{1'b0}};
         out_cmax     <= {COL_W{1'b0}};
`ifdef BBOX_CENTROID_EN
         out_rsum     <= {SUM_W{1'b0}};
         out_csum     <= {SUM_W{1'b0}};
`endif
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r   <= ST_CLEAR;
                  busy      <= 1'b1;
                  overflow  <= 1'b0;
                  clr_idx_r <= {IDX_W{1'b0}};
                  sram_a    <= {ADDR_W{1'b0}};
               end
            end
            ST_CLEAR: begin
               proc_valid_r <= 1'b0;
               if (clr_idx_r == IDX_W'(MAX_LABEL - 1)) state_r <= ST_SCAN;
               else clr_idx_r <= clr_idx_r + IDX_W'(1);
            end
            ST_SCAN: begin
               // sram data lags the address by one cycle, so the processed address trails sram_a
               proc_valid_r <= 1'b1;
               proc_addr_r  <= sram_a;
               if (ovf_hit_s) overflow <= 1'b1;
               if (sram_a == {ADDR_W{1'b1}}) state_r <= ST_DRAIN;
               else sram_a <= sram_a + ADDR_W'(1);
            end
            ST_DRAIN: begin
               proc_valid_r <= 1'b0;
               if (ovf_hit_s) overflow <= 1'b1;
               emit_idx_r   <= IDX_W'(1);
               state_r      <= ST_EMIT;
            end
            ST_EMIT: begin
               if (out_valid) begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     if (last_idx_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        emit_idx_r <= emit_idx_r + IDX_W'(1);
                     end
                  end
               end else if (cnt_r[emit_idx_r] != {CNT_W{1'b0}}) begin
                  out_valid <= 1'b1;
                  out_label <= {{(LABEL_W - IDX_W){1'b0}}, emit_idx_r};
                  out_count <= cnt_r[emit_idx_r];
                  out_rmin  <= rmin_r[emit_idx_r];
                  out_rmax  <= rmax_r[emit_idx_r];
                  out_cmin  <= cmin_r[emit_idx_r];
                  out_cmax  <= cmax_r[emit_idx_r];
`ifdef BBOX_CENTROID_EN
                  out_rsum  <= rsum_r[emit_idx_r];
                  out_csum  <= csum_r[emit_idx_r];
`endif
               end else if (last_idx_s) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  emit_idx_r <= emit_idx_r + IDX_W'(1);
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
